mmcm_drp_reconfig: RTL

//  DRP master for the board MMCME2_ADV: drives DADDR/DEN/DWE/DI/RST, consumes DO/DRDY/LOCKED.
//  On a start request, rewrites a preset list of MMCM registers by read-modify-write, holding the MMCM in reset.

---
 rtl/mmcm_drp_pkg.sv | 52 +++++
 rtl/mmcm_drp_rom.sv | 34 +++
 rtl/mmcm_drp_reconfig.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mmcm_drp_pkg.sv
// Shared types and constants for the MMCME2_ADV DRP reconfiguration master:
// register addresses, preset-table entry layout, FSM states and error codes.
package mmcm_drp_pkg;

    // DRP register addresses (reg1 = high/low time, reg2 = edge/no_count/phase)
    localparam logic [6:0] ADDR_CLKOUT5_1  = 7'h06;
    localparam logic [6:0] ADDR_CLKOUT5_2  = 7'h07;
    localparam logic [6:0] ADDR_CLKOUT0_1  = 7'h08;
    localparam logic [6:0] ADDR_CLKOUT0_2  = 7'h09;
    localparam logic [6:0] ADDR_CLKOUT1_1  = 7'h0A;
    localparam logic [6:0] ADDR_CLKOUT1_2  = 7'h0B;
    localparam logic [6:0] ADDR_CLKOUT2_1  = 7'h0C;
    localparam logic [6:0] ADDR_CLKOUT2_2  = 7'h0D;
    localparam logic [6:0] ADDR_CLKOUT3_1  = 7'h0E;
    localparam logic [6:0] ADDR_CLKOUT3_2  = 7'h0F;
    localparam logic [6:0] ADDR_CLKOUT4_1  = 7'h10;
    localparam logic [6:0] ADDR_CLKOUT4_2  = 7'h11;
    localparam logic [6:0] ADDR_CLKOUT6_1  = 7'h12;
    localparam logic [6:0] ADDR_CLKOUT6_2  = 7'h13;
    localparam logic [6:0] ADDR_CLKFBOUT_1 = 7'h14;
    localparam logic [6:0] ADDR_CLKFBOUT_2 = 7'h15;
    localparam logic [6:0] ADDR_DIVCLK     = 7'h16;

    // Mask bit 1 = keep the bit read back from the MMCM
    localparam logic [15:0] MASK_REG1     = 16'hF000;
    localparam logic [15:0] MASK_REG2     = 16'hFF3F;
    localparam logic [15:0] MASK_KEEP_ALL = 16'hFFFF;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
    } drp_entry_t;

    typedef enum logic [3:0] {
        IDLE, RST_ON, RD, RD_WAIT, WR, WR_WAIT, NEXT, RST_OFF, LOCK_WAIT, FINISH
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_DRDY_TMO = 2'd1;
    localparam logic [1:0] ERR_LOCK_TMO = 2'd2;
    localparam logic [1:0] ERR_BAD_CFG  = 2'd3;

    function automatic drp_entry_t mk_entry(logic [6:0] addr, logic [15:0] mask, logic [15:0] data);
        drp_entry_t e;
        e.addr = addr;
        e.mask = mask;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/mmcm_drp_rom.sv
// Preset DRP table: (cfg, idx) -> {addr, mask, data}. cfg 0 is the power-up
// setting (FB x8, OUT0 /16, OUT1 /8, OUT2 /5, OUT3 /32); cfg 1 retunes OUT0 to /10.
module mmcm_drp_rom
    import mmcm_drp_pkg::*;
#(
    parameter int CW = 1,
    parameter int IW = 3
) (
    input  logic [CW-1:0] cfg,
    input  logic [IW-1:0] idx,
    output drp_entry_t    entry
);

    logic alt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alt   = (int'(cfg) == 1);
        entry = mk_entry(ADDR_DIVCLK, MASK_KEEP_ALL, 16'h0000);
        case (int'(idx))
            0: entry = mk_entry(ADDR_CLKFBOUT_1, MASK_REG1, 16'h0104);
            1: entry = mk_entry(ADDR_CLKFBOUT_2, MASK_REG2, 16'h0000);
            2: entry = mk_entry(ADDR_CLKOUT0_1,  MASK_REG1, alt ? 16'h0145 : 16'h0208);
            3: entry = mk_entry(ADDR_CLKOUT0_2,  MASK_REG2, 16'h0000);
            4: entry = mk_entry(ADDR_CLKOUT1_1,  MASK_REG1, 16'h0104);
            5: entry = mk_entry(ADDR_CLKOUT2_1,  MASK_REG1, 16'h0083);
            6: entry = mk_entry(ADDR_CLKOUT2_2,  MASK_REG2, 16'h0080);
            7: entry = mk_entry(ADDR_CLKOUT3_1,  MASK_REG1, 16'h0410);
            // Out-of-table indices rewrite DIVCLK with itself: a harmless no-op
            default: entry = mk_entry(ADDR_DIVCLK, MASK_KEEP_ALL, 16'h0000);
        endcase
    end

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// DRP master that rewrites a preset MMCM register list by read-modify-write
// while holding the MMCM in reset, then waits for LOCKED and reports the outcome.
module mmcm_drp_reconfig
    import mmcm_drp_pkg::*;
#(
    parameter  int N_CFG    = 2,
    parameter  int N_REGS   = 8,
    parameter  int DRDY_TMO = 64,
    parameter  int LOCK_TMO = 65535,
    localparam int CW       = (N_CFG > 1) ? $clog2(N_CFG) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] cfg_sel,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [1:0]    err_code,
    output logic [6:0]    daddr,
    output logic          den,
    output logic          dwe,
    output logic [15:0]   di,
    input  logic [15:0]   do_i,
    input  logic          drdy,
    output logic          mmcm_rst,
    input  logic          locked
);

    localparam int IW      = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int TMO_MAX = (DRDY_TMO > LOCK_TMO) ? DRDY_TMO : LOCK_TMO;
    localparam int CNT_W   = $clog2(TMO_MAX + 1);

    // The DEN (or RST_OFF) cycle and the clearing edge already use two of the allowed cycles
    localparam logic [CNT_W-1:0] DRDY_LIMIT = CNT_W'(DRDY_TMO - 2);
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_TMO - 2);
    localparam logic [IW-1:0]    IDX_LAST   = IW'(N_REGS - 1);
    localparam logic [CW:0]      N_CFG_W    = (CW + 1)'(N_CFG);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cfg_q, cfg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      rd_q, rd_d;
    logic             error_q, error_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             locked_meta, locked_s;
    logic             cfg_bad;
    drp_entry_t       entry;

    mmcm_drp_rom #(.CW(CW), .IW(IW)) u_rom (
        .cfg   (cfg_q),
        .idx   (idx_q),
        .entry (entry)
    );

    assign cfg_bad  = {1'b0, cfg_sel} >= N_CFG_W;
    assign error    = error_q;
    assign err_code = err_code_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            locked_meta <= locked;
            locked_s    <= locked_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cfg_q      <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cfg_q      <= cfg_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cfg_d      = cfg_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        busy       = 1'b1;
        done       = 1'b0;
        daddr      = '0;
        den        = 1'b0;
        dwe        = 1'b0;
        di         = '0;
        mmcm_rst   = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (cfg_bad) begin
                        error_d    = 1'b1;
                        err_code_d = ERR_BAD_CFG;
                    end else begin
                        cfg_d      = cfg_sel;
                        error_d    = 1'b0;
                        err_code_d = ERR_NONE;
                        idx_d      = '0;
                        state_d    = RST_ON;
                    end
                end
            end
            RST_ON: begin
                mmcm_rst = 1'b1;
                state_d  = RD;
            end
            RD: begin
                mmcm_rst = 1'b1;
                daddr    = entry.addr;
                den      = 1'b1;
                cnt_d    = '0;
                state_d  = RD_WAIT;
            end
            RD_WAIT: begin
                mmcm_rst = 1'b1;
                if (drdy) begin
                    rd_d    = do_i;
                    state_d = WR;
                end else if (cnt_q >= DRDY_LIMIT) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_DRDY_TMO;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR: begin
                mmcm_rst = 1'b1;
                daddr    = entry.addr;
                den      = 1'b1;
                dwe      = 1'b1;
                di       = (rd_q & entry.mask) | (entry.data & ~entry.mask);
                cnt_d    = '0;
                state_d  = WR_WAIT;
            end
            WR_WAIT: begin
                mmcm_rst = 1'b1;
                if (drdy) begin
                    state_d = NEXT;
                end else if (cnt_q >= DRDY_LIMIT) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_DRDY_TMO;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            NEXT: begin
                mmcm_rst = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = RST_OFF;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = RD;
                end
            end
            RST_OFF: begin
                cnt_d   = '0;
                state_d = LOCK_WAIT;
            end
            LOCK_WAIT: begin
                if (locked_s) begin
                    state_d = FINISH;
                end else if (cnt_q >= LOCK_LIMIT) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_LOCK_TMO;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FINISH: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule
